// File: rtl/match_sequencer.sv
// rtl/match_sequencer.sv - quidditch round sequencer with time-shared hoop scanner
module match_sequencer #(
  parameter int unsigned TICK_DIV         = 'd25000000,
  parameter int unsigned SERVE_TICKS      = 3,
  parameter int unsigned GOAL_PAUSE_TICKS = 2,
  parameter int unsigned WIN_SCORE        = 7,
  parameter int unsigned BALL_RADIUS      = 10,
  parameter int unsigned GOAL_RADIUS      = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       game_on,
  output logic       game_over,
  output logic       ball_reset,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] last_scorer,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_GOAL  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  // Terminal phase values: the phase counter runs 0..LAST, so the state lasts LAST+1 cycles.
  localparam logic [31:0] SERVE_LAST = 32'(SERVE_TICKS * TICK_DIV - 1);
  localparam logic [31:0] GOAL_LAST  = 32'(GOAL_PAUSE_TICKS * TICK_DIV - 1);
  localparam logic [21:0] HIT_R2     = 22'((GOAL_RADIUS - BALL_RADIUS) * (GOAL_RADIUS - BALL_RADIUS));
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  state_t      state_q, state_d;
  logic [31:0] phase_q, phase_d;
  logic [3:0]  score1_q, score1_d, score2_q, score2_d;
  logic [1:0]  last_scorer_q, last_scorer_d;
  logic        game_on_q, game_on_d, game_over_q, game_over_d, ball_reset_q, ball_reset_d;
  logic [2:0]  scan_idx_q, scan_idx_d;
  logic [9:0]  snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic        hit_q, hit_d;
  logic [1:0]  hit_team_q, hit_team_d;

  logic [9:0]         hx, hy;
  logic signed [10:0] dx, dy;
  logic signed [21:0] dx_w, dy_w;
  logic [21:0]        d2;
  logic [3:0]         scorer_score;

  // Scanner: one hoop per cycle against a snapshot taken at idx 0 (bypassed on that cycle).
  always_comb begin
    hx = 10'd300;
    hy = 10'd100;
    case (scan_idx_q)
      3'd0: begin hx = 10'd300; hy = 10'd100; end
      3'd1: begin hx = 10'd400; hy = 10'd100; end
      3'd2: begin hx = 10'd500; hy = 10'd100; end
      3'd3: begin hx = 10'd300; hy = 10'd450; end
      3'd4: begin hx = 10'd400; hy = 10'd450; end
      3'd5: begin hx = 10'd500; hy = 10'd450; end
      default: begin hx = 10'd300; hy = 10'd100; end
    endcase
    scan_idx_d = (scan_idx_q == 3'd5) ? 3'd0 : scan_idx_q + 3'd1;
    snap_x_d   = (scan_idx_q == 3'd0) ? ball_x : snap_x_q;
    snap_y_d   = (scan_idx_q == 3'd0) ? ball_y : snap_y_q;
    dx         = $signed({1'b0, snap_x_d}) - $signed({1'b0, hx});
    dy         = $signed({1'b0, snap_y_d}) - $signed({1'b0, hy});
    dx_w       = {{11{dx[10]}}, dx};
    dy_w       = {{11{dy[10]}}, dy};
    d2         = dx_w * dx_w + dy_w * dy_w;
    hit_d      = (d2 < HIT_R2);
    // Red hoops (idx 0..2) score for team2, blue hoops for team1.
    hit_team_d = (scan_idx_q < 3'd3) ? 2'd2 : 2'd1;
  end

  // Match flow: next state, phase counter, scores and registered output values.
  always_comb begin
    state_d       = state_q;
    phase_d       = 32'd0;
    score1_d      = score1_q;
    score2_d      = score2_q;
    last_scorer_d = last_scorer_q;
    scorer_score  = (last_scorer_q == 2'd1) ? score1_q : score2_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_SERVE;
      S_SERVE: begin
        if (phase_q == SERVE_LAST) state_d = S_PLAY;
        else                       phase_d = phase_q + 32'd1;
      end
      S_PLAY: begin
        if (hit_q) begin
          state_d       = S_GOAL;
          last_scorer_d = hit_team_q;
          if (hit_team_q == 2'd1) score1_d = (score1_q == 4'd15) ? 4'd15 : score1_q + 4'd1;
          else                    score2_d = (score2_q == 4'd15) ? 4'd15 : score2_q + 4'd1;
        end
      end
      S_GOAL: begin
        if (phase_q == GOAL_LAST) state_d = (scorer_score >= WIN) ? S_OVER : S_SERVE;
        else                      phase_d = phase_q + 32'd1;
      end
      S_OVER: begin
        if (start) begin
          state_d       = S_SERVE;
          score1_d      = 4'd0;
          score2_d      = 4'd0;
          last_scorer_d = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    game_on_d    = (state_d == S_PLAY);
    game_over_d  = (state_d == S_OVER);
    ball_reset_d = (state_d == S_SERVE) && (state_q != S_SERVE);
  end

  // All state and outputs register here; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= 32'd0;
      score1_q      <= 4'd0;
      score2_q      <= 4'd0;
      last_scorer_q <= 2'd0;
      game_on_q     <= 1'b0;
      game_over_q   <= 1'b0;
      ball_reset_q  <= 1'b0;
      scan_idx_q    <= 3'd0;
      snap_x_q      <= 10'd0;
      snap_y_q      <= 10'd0;
      hit_q         <= 1'b0;
      hit_team_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      last_scorer_q <= last_scorer_d;
      game_on_q     <= game_on_d;
      game_over_q   <= game_over_d;
      ball_reset_q  <= ball_reset_d;
      scan_idx_q    <= scan_idx_d;
      snap_x_q      <= snap_x_d;
      snap_y_q      <= snap_y_d;
      hit_q         <= hit_d;
      hit_team_q    <= hit_team_d;
    end
  end

  assign game_on     = game_on_q;
  assign game_over   = game_over_q;
  assign ball_reset  = ball_reset_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign last_scorer = last_scorer_q;
  assign state_dbg   = state_q;

endmodule
